// File: rtl/pi_speed_ctrl.sv
// pi_speed_ctrl: fixed-point PI speed controller for the PWM stage.
// A measurement strobe starts a four-cycle update. The cycles are error,
// multiply/accumulate, sum/shift and output clamp. The result is a
// saturated 11-bit duty count. pwm_count only moves at the output step,
// on reset, or while the controller is disabled.
module pi_speed_ctrl #(
  parameter int SHIFT   = 6,
  parameter int I_LIM   = 1048575,
  parameter int PWM_MAX = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] setpoint,
  input  logic [11:0] meas,
  input  logic        meas_valid,
  input  logic [7:0]  kp,
  input  logic [7:0]  ki,
  output logic [10:0] pwm_count,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    MAC  = 3'd2,
    SUM  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Clamp limits, widened to the 25-bit working width.
  localparam logic signed [24:0] I_LIM_POS = 25'(I_LIM);
  localparam logic signed [24:0] I_LIM_NEG = -I_LIM_POS;
  localparam logic signed [24:0] PWM_MAX_S = 25'(PWM_MAX);
  localparam logic        [10:0] PWM_MAX_U = 11'(PWM_MAX);

  state_t             state_reg;

  // Operands captured at the strobe and held for the whole update.
  logic [11:0]        sp_reg;
  logic [11:0]        meas_reg;
  logic [7:0]         kp_reg;
  logic [7:0]         ki_reg;

  // Pipeline of intermediate results, one register per step.
  logic signed [12:0] err_reg;
  logic signed [20:0] p_reg;
  logic signed [23:0] i_acc_reg;
  logic signed [24:0] u_reg;

  // Combinational next values for each step.
  logic signed [12:0] err_next;
  logic signed [21:0] kp_ext;
  logic signed [21:0] ki_ext;
  logic signed [21:0] err_ext;
  logic signed [21:0] p_full;
  logic signed [21:0] ki_full;
  logic signed [24:0] i_sum;
  logic signed [24:0] i_next;
  logic signed [24:0] u_next;
  logic [10:0]        pwm_next;

  // Datapath arithmetic. Each value is only consumed in its own FSM state.
  always_comb begin
    err_next = $signed({1'b0, sp_reg}) - $signed({1'b0, meas_reg});

    // Gains are unsigned, so they are zero-extended before the signed
    // multiplies. Both products fit within +/-1044225.
    kp_ext  = $signed({14'd0, kp_reg});
    ki_ext  = $signed({14'd0, ki_reg});
    err_ext = 22'(err_reg);
    p_full  = kp_ext * err_ext;
    ki_full = ki_ext * err_ext;

    // Anti-windup: the accumulator never leaves +/-I_LIM.
    i_sum = 25'(i_acc_reg) + 25'(ki_full);
    if (i_sum > I_LIM_POS) begin
      i_next = I_LIM_POS;
    end else if (i_sum < I_LIM_NEG) begin
      i_next = I_LIM_NEG;
    end else begin
      i_next = i_sum;
    end

    // Arithmetic shift floors toward -infinity. This uses the updated i_acc.
    u_next = (25'(p_reg) + 25'(i_acc_reg)) >>> SHIFT;

    // Saturate to the PWM range; negative demand means zero duty.
    if (u_reg < 25'sd0) begin
      pwm_next = 11'd0;
    end else if (u_reg > PWM_MAX_S) begin
      pwm_next = PWM_MAX_U;
    end else begin
      pwm_next = u_reg[10:0];
    end
  end

  // Control FSM and all state. Disable has priority over any update in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sp_reg    <= '0;
      meas_reg  <= '0;
      kp_reg    <= '0;
      ki_reg    <= '0;
      err_reg   <= '0;
      p_reg     <= '0;
      i_acc_reg <= '0;
      u_reg     <= '0;
      pwm_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (!enable) begin
      state_reg <= IDLE;
      i_acc_reg <= '0;
      pwm_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (meas_valid) begin
            sp_reg    <= setpoint;
            meas_reg  <= meas;
            kp_reg    <= kp;
            ki_reg    <= ki;
            busy      <= 1'b1;
            state_reg <= ERR;
          end
        end
        ERR: begin
          err_reg   <= err_next;
          state_reg <= MAC;
        end
        MAC: begin
          p_reg     <= p_full[20:0];
          i_acc_reg <= i_next[23:0];
          state_reg <= SUM;
        end
        SUM: begin
          u_reg     <= u_next;
          state_reg <= OUT;
        end
        OUT: begin
          pwm_count <= pwm_next;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
